// File: rtl/rf_wb_arbiter_pkg.sv
// Shared register-file constants and types for the writeback arbiter slice.
package rf_wb_arbiter_pkg;

    localparam int unsigned REG_AW  = 5;
    localparam int unsigned REG_CNT = 32;

    typedef logic [REG_AW-1:0] regAddr_t;

    localparam regAddr_t REG_X0 = '0;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

endpackage

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Pending-write scoreboard: busy vector, outstanding port-B count, sticky error, hazard.
module rf_wb_arbiter_scoreboard
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUT = 4
)
(
    input  logic     clk,
    input  logic     rst,
    input  logic     issValid,
    input  regAddr_t issRd,
    output logic     issReady,
    input  regAddr_t rs1,
    input  regAddr_t rs2,
    input  logic     bXfer,
    input  regAddr_t bRd,
    output logic     hazard,
    output logic     err
);

    localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUT);

    logic [REG_CNT-1:0] busy;
    logic [REG_CNT-1:0] busyNext;
    logic [3:0]         outCnt;
    logic [3:0]         outCntNext;
    logic               issAccept;
    logic               orphanWrite;

    assign issReady    = (outCnt < MAX_OUT_C);
    assign issAccept   = issValid && issReady;
    assign orphanWrite = bXfer && (!busy[bRd] || (outCnt == '0));
    assign hazard      = busy[rs1] || busy[rs2] || (issValid && busy[issRd]);

    always_comb begin
        busyNext = busy;
        // Clear before set so a same-cycle issue to the retiring register stays pending.
        if (bXfer)
            busyNext[bRd] = 1'b0;
        if (issAccept && (issRd != REG_X0))
            busyNext[issRd] = 1'b1;
        busyNext[REG_X0] = 1'b0;

        outCntNext = outCnt;
        if (issAccept && !bXfer)
            outCntNext = outCnt + 4'd1;
        else if (!issAccept && bXfer && (outCnt != '0))
            outCntNext = outCnt - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy   <= '0;
            outCnt <= '0;
            err    <= 1'b0;
        end else begin
            busy   <= busyNext;
            outCnt <= outCntNext;
            err    <= err || orphanWrite;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter between the ALU (port A) and long-latency (port B)
// writeback paths, with starvation guard for port B and a pending-write scoreboard.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned MAX_OUT  = 4
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             iss_valid,
    input  logic [4:0]       iss_rd,
    output logic             iss_ready,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    output logic             hazard,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [4:0]       a_rd,
    input  logic [WIDTH-1:0] a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [4:0]       b_rd,
    input  logic [WIDTH-1:0] b_data,
    output logic             WR,
    output logic [4:0]       AddrD,
    output logic [WIDTH-1:0] DataD,
    output logic             err
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0] waitCnt;
    logic       forceB;
    logic       aXfer;
    logic       bXfer;
    grant_e     grant;

    assign forceB  = (waitCnt == MAX_WAIT_C);
    assign grant   = (b_valid && (!a_valid || forceB)) ? GRANT_B : GRANT_A;
    assign a_ready = rst && (!forceB || !b_valid);
    assign b_ready = rst && (grant == GRANT_B);
    assign aXfer   = a_valid && a_ready;
    assign bXfer   = b_valid && b_ready;

    always_comb begin
        WR    = aXfer && (a_rd != REG_X0);
        AddrD = a_rd;
        DataD = a_data;
        if (grant == GRANT_B) begin
            WR    = bXfer && (b_rd != REG_X0);
            AddrD = b_rd;
            DataD = b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            waitCnt <= '0;
        else if (!b_valid || bXfer)
            waitCnt <= '0;
        else
            waitCnt <= waitCnt + 4'd1;
    end

    rf_wb_arbiter_scoreboard #(
        .MAX_OUT (MAX_OUT)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .issValid (iss_valid),
        .issRd    (iss_rd),
        .issReady (iss_ready),
        .rs1      (rs1),
        .rs2      (rs2),
        .bXfer    (bXfer),
        .bRd      (b_rd),
        .hazard   (hazard),
        .err      (err)
    );

endmodule
